// File: rtl/aes_pkg.sv
// Shared types, GF(2^8) helpers and FSM encoding for the AES inverse round engine.
package aes_pkg;

    typedef logic [7:0]       aes_byte_t;
    // Index 3 of a column is row 0 (the most significant byte).
    typedef aes_byte_t [3:0]  aes_col_t;
    // Index 3 of a state is column 0 (the most significant word).
    typedef aes_col_t  [3:0]  aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Reduction constant for the AES field polynomial x^8+x^4+x^3+x+1.
    localparam aes_byte_t GF_RED = 8'h1b;

    function automatic aes_byte_t gf_xtime(input aes_byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
    endfunction

    function automatic aes_byte_t gf_mul_9(input aes_byte_t a);
        aes_byte_t x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ a;
    endfunction

    function automatic aes_byte_t gf_mul_b(input aes_byte_t a);
        aes_byte_t x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x2 ^ a;
    endfunction

    function automatic aes_byte_t gf_mul_d(input aes_byte_t a);
        aes_byte_t x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic aes_byte_t gf_mul_e(input aes_byte_t a);
        aes_byte_t x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: 256x8 constant table lookup.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry i lives at bits [2047-8i -: 8], i.e. row 0 of the table is the top word.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Byte i sits at bit offset 8*(255-i); 255-i is simply the bitwise inverse of i.
    logic [10:0] bit_base;

    assign bit_base = {~in_byte, 3'b000};
    assign out_byte = INV_SBOX[bit_base +: 8];

endmodule

// File: rtl/aes_inv_round.sv
// Column-serial AES inverse-cipher round: InvShiftRows, InvSubBytes,
// AddRoundKey and (unless final round) InvMixColumns, one column per cycle.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         last_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] state_o
);

    fsm_t       fsm_reg, fsm_next;
    logic [1:0] col_cnt_reg;
    aes_state_t in_state_reg;
    aes_state_t rkey_reg;
    logic       last_reg;
    aes_state_t result_reg;

    logic       accept;
    aes_col_t   t_col, u_col, v_col, w_col;

    // Ready never looks at in_valid_i; a finished block frees the engine
    // in the same cycle it is taken downstream.
    assign in_ready_o  = (fsm_reg == IDLE) || ((fsm_reg == DONE) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (fsm_reg == DONE);
    assign state_o     = result_reg;

    // Next-state logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            IDLE: if (accept) fsm_next = BUSY;
            BUSY: if (col_cnt_reg == 2'd3) fsm_next = DONE;
            DONE: if (out_ready_i) fsm_next = in_valid_i ? BUSY : IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    // Per-row column datapath. The source column for row r is rotated by r,
    // which implements InvShiftRows without touching the captured input.
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        localparam int         IDX = 3 - gi;
        localparam logic [1:0] ROW = 2'(gi);
        localparam int         IDX1 = 3 - ((gi + 1) % 4);
        localparam int         IDX2 = 3 - ((gi + 2) % 4);
        localparam int         IDX3 = 3 - ((gi + 3) % 4);

        logic [1:0] src_col;
        aes_byte_t  mix_byte;

        assign src_col    = col_cnt_reg - ROW;
        assign t_col[IDX] = in_state_reg[~src_col][IDX];

        aes_inv_sbox u_inv_sbox (
            .in_byte  (t_col[IDX]),
            .out_byte (u_col[IDX])
        );

        assign v_col[IDX] = u_col[IDX] ^ rkey_reg[~col_cnt_reg][IDX];

        // Circulant {0e,0b,0d,09} row of the InvMixColumns matrix.
        assign mix_byte   = gf_mul_e(v_col[IDX])  ^ gf_mul_b(v_col[IDX1]) ^
                            gf_mul_d(v_col[IDX2]) ^ gf_mul_9(v_col[IDX3]);
        assign w_col[IDX] = last_reg ? v_col[IDX] : mix_byte;
    end

    // Sequencer state and column counter; the counter wraps 3->0 entering DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_reg     <= IDLE;
            col_cnt_reg <= 2'd0;
        end else begin
            fsm_reg <= fsm_next;
            if (fsm_reg == BUSY) begin
                col_cnt_reg <= col_cnt_reg + 2'd1;
            end
        end
    end

    // Capture registers load on accept; the result register takes one column per BUSY cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_state_reg <= '0;
            rkey_reg     <= '0;
            last_reg     <= 1'b0;
            result_reg   <= '0;
        end else begin
            if (accept) begin
                in_state_reg <= state_i;
                rkey_reg     <= rkey_i;
                last_reg     <= last_i;
            end
            if (fsm_reg == BUSY) begin
                result_reg[~col_cnt_reg] <= w_col;
            end
        end
    end

endmodule

// File: tb/tb_aes_inv_round.sv
// Randomized bench for aes_inv_round with a block-level reference model.
module tb_aes_inv_round;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [127:0] state_i = '0;
    logic [127:0] rkey_i = '0;
    logic         last_i = 1'b0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic [127:0] state_o;

    always #5 clk = ~clk;

    aes_inv_round dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .state_i     (state_i),
        .rkey_i      (rkey_i),
        .last_i      (last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .state_o     (state_o)
    );

    localparam logic [127:0] V1_ST  = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V1_EXP = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V2_ST  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] V2_KEY = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] V2_EXP = 128'h54d990a16ba09ab596bbf40ea111702f;

    int n_vec = 0;
    int n_err = 0;
    int n_xfer = 0;

    logic [7:0] inv_sb [256];

    // Reference model state
    int           m_busy = 0;
    bit           m_have_out = 0;
    bit           m_zero = 0;
    bit           m_started = 0;
    bit           acc_flag = 0;
    logic [127:0] m_out = '0;
    logic [127:0] m_pend = '0;

    bit rand_rdy = 0;
    bit scramble = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Inverse S-box derived from field inversion plus the forward affine map.
    task automatic build_inv_sbox();
        logic [7:0] y;
        logic [7:0] s;
        logic [7:0] xb;
        for (int x = 0; x < 256; x++) begin
            xb = 8'(x);
            y = 8'h00;
            for (int z = 1; z < 256; z++) begin
                if (gmul(xb, 8'(z)) == 8'h01) y = 8'(z);
            end
            s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
            inv_sb[s] = xb;
        end
    endtask

    // Whole-block inverse round computed on a row/column matrix.
    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic lst);
        logic [7:0] s [4][4];
        logic [7:0] v [4][4];
        logic [7:0] w [4][4];
        logic [7:0] coef [4];
        logic [127:0] res;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = st[127 - 32*c - 8*r -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                v[r][c] = inv_sb[s[r][(c - r + 4) % 4]] ^ key[127 - 32*c - 8*r -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (lst) begin
                    w[r][c] = v[r][c];
                end else begin
                    w[r][c] = 8'h00;
                    for (int j = 0; j < 4; j++)
                        w[r][c] = w[r][c] ^ gmul(coef[(j - r + 4) % 4], v[j][c]);
                end
                res[127 - 32*c - 8*r -: 8] = w[r][c];
            end
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timeout waiting for DUT at %0t", name, $time);
    endtask

    // Transaction-level model: a block takes 4 edges, then waits for downstream.
    always @(posedge clk) begin
        bit exp_rdy;
        acc_flag = 0;
        if (rst_i) begin
            m_busy = 0;
            m_have_out = 0;
            m_out = '0;
            m_zero = 1;
            m_started = 1;
        end else begin
            exp_rdy = (m_busy == 0) && (!m_have_out || out_ready_i);
            if (m_have_out && out_ready_i) begin
                m_have_out = 0;
                n_xfer++;
                $display("xfer %0d: result %h", n_xfer, m_out);
            end
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_have_out = 1;
                    m_out = m_pend;
                end
            end
            if (in_valid_i && exp_rdy) begin
                m_pend = ref_round(state_i, rkey_i, last_i);
                m_busy = 4;
                m_zero = 0;
                acc_flag = 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_started && !rst_i) begin
            chk("out_valid", 128'(out_valid_o), 128'(m_have_out));
            chk("in_ready", 128'(in_ready_o),
                128'((m_busy == 0) && (!m_have_out || out_ready_i)));
            if (m_have_out || m_zero) chk("state_o", state_o, m_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready_i = 1'($urandom_range(0, 1));
        if (scramble && !in_valid_i) begin
            state_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            rkey_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
            last_i  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send(input logic [127:0] st, input logic [127:0] key, input logic lst,
                        output int cycles);
        in_valid_i = 1'b1;
        state_i = st;
        rkey_i = key;
        last_i = lst;
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!acc_flag && cycles < 200);
        if (!acc_flag) timeout("send_accept");
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !out_valid_o; i++) tick();
        if (!out_valid_o) timeout("wait_valid");
    endtask

    initial begin
        int cyc;
        int cyc2;
        logic [127:0] rs;
        logic [127:0] rk;

        build_inv_sbox();
        chk("gmul_57_83", 128'(gmul(8'h57, 8'h83)), 128'h00c1);
        chk("model_v1", ref_round(V1_ST, V1_KEY, 1'b1), V1_EXP);
        chk("model_v2", ref_round(V2_ST, V2_KEY, 1'b0), V2_EXP);

        // Reset state
        rst_i = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", 128'(out_valid_o), 128'(0));
        chk("rst_state", state_o, 128'(0));
        chk("rst_in_ready", 128'(in_ready_o), 128'(1));
        rst_i = 1'b0;
        tick();

        // Final round with exact latency
        out_ready_i = 1'b1;
        send(V1_ST, V1_KEY, 1'b1, cyc);
        in_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lat_wait", 128'(out_valid_o), 128'(0));
        end
        tick();
        chk("lat_valid", 128'(out_valid_o), 128'(1));
        chk("t1_state", state_o, V1_EXP);
        tick();

        // Middle round
        send(V2_ST, V2_KEY, 1'b0, cyc);
        in_valid_i = 1'b0;
        wait_valid();
        chk("t2_state", state_o, V2_EXP);
        tick();

        // Backpressure
        out_ready_i = 1'b0;
        send(V1_ST, V1_KEY, 1'b1, cyc);
        in_valid_i = 1'b0;
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_state", state_o, V1_EXP);
            chk("bp_valid", 128'(out_valid_o), 128'(1));
            chk("bp_in_ready", 128'(in_ready_o), 128'(0));
        end
        out_ready_i = 1'b1;
        tick();
        chk("bp_release_valid", 128'(out_valid_o), 128'(0));
        chk("bp_release_ready", 128'(in_ready_o), 128'(1));

        // Back-to-back accepts
        send(V1_ST, V1_KEY, 1'b1, cyc);
        send(V2_ST, V2_KEY, 1'b0, cyc2);
        chk("b2b_gap", 128'(cyc2), 128'(5));
        in_valid_i = 1'b0;
        wait_valid();
        chk("b2b_second", state_o, V2_EXP);
        tick();

        // Reset in the middle of a block
        send(V2_ST, V2_KEY, 1'b0, cyc);
        in_valid_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        chk("midrst_valid", 128'(out_valid_o), 128'(0));
        chk("midrst_state", state_o, 128'(0));
        chk("midrst_ready", 128'(in_ready_o), 128'(1));
        rst_i = 1'b0;
        send(V1_ST, V1_KEY, 1'b1, cyc);
        in_valid_i = 1'b0;
        wait_valid();
        chk("midrst_result", state_o, V1_EXP);
        tick();

        // Inputs change every cycle after the accept
        scramble = 1;
        send(V2_ST, V2_KEY, 1'b0, cyc);
        in_valid_i = 1'b0;
        wait_valid();
        chk("stable_result", state_o, V2_EXP);
        tick();

        // Random sweep
        rand_rdy = 1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            rs = {$urandom(), $urandom(), $urandom(), $urandom()};
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(rs, rk, 1'($urandom_range(0, 1)), cyc);
            in_valid_i = 1'b0;
        end
        rand_rdy = 0;
        out_ready_i = 1'b1;
        repeat (10) tick();
        chk("drain_idle", 128'(out_valid_o), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
